// File: rtl/updown_count_sched_if.sv
// Requester/counter-control bundle for updown_count_sched.
// master = requester side (drives requests), slave = scheduler side.
// ReqLen packs one LEN_W-bit length per requester, requester i at [i*LEN_W +: LEN_W].
interface updown_count_sched_if #(parameter int LEN_W = 4);
  logic [1:0]         ReqValid;
  logic [1:0]         ReqReady;
  logic [1:0]         ReqOp;
  logic [2*LEN_W-1:0] ReqLen;
  logic               Enable;
  logic               Swap;
  logic               Busy;
  logic               Done;
  logic               DoneId;

  modport master (
    output ReqValid, ReqOp, ReqLen,
    input  ReqReady, Enable, Swap, Busy, Done, DoneId
  );

  modport slave (
    input  ReqValid, ReqOp, ReqLen,
    output ReqReady, Enable, Swap, Busy, Done, DoneId
  );
endinterface

// File: rtl/updown_count_sched.sv
// Purpose: arbitrates two requesters and turns each granted command into an exact
//          Enable/Swap burst followed by a one-cycle Done pulse tagged with the requester.
// Latency: count L -> L+2 cycles handshake-to-handshake; swap -> 3 cycles.
// Backpressure: ReqReady only in IDLE, at most one-hot; requesters hold their command until ready.
// Optional: define UDC_FIXED_PRIO_EN for fixed priority (requester 0 always wins a tie).
module updown_count_sched #(
  parameter int LEN_W = 4
) (
  input logic                 Clock,
  input logic                 Reset_n,
  updown_count_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, SWP, FIN} state_t;

  state_t           state;
  logic             owner;
  logic [LEN_W-1:0] rem;
  logic             enable;
  logic             swap;
  logic             busy;
  logic             done;
  logic             done_id;
`ifndef UDC_FIXED_PRIO_EN
  logic             prio;
`endif

  logic [1:0]       grant;
  logic             gsel;
  logic             op_sel;
  logic [LEN_W-1:0] len_sel;

  // Arbitration: grant only in IDLE and never while reset is held.
  always_comb begin
    grant = 2'b00;
    if (Reset_n && state == IDLE) begin
      if (bus.ReqValid == 2'b11) begin
`ifdef UDC_FIXED_PRIO_EN
        grant = 2'b01;
`else
        grant = prio ? 2'b10 : 2'b01;
`endif
      end else begin
        grant = bus.ReqValid;
      end
    end
    gsel    = grant[1];
    op_sel  = bus.ReqOp[gsel];
    len_sel = gsel ? bus.ReqLen[2*LEN_W-1:LEN_W] : bus.ReqLen[LEN_W-1:0];
  end

  // Control FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state   <= IDLE;
      owner   <= 1'b0;
      rem     <= '0;
      enable  <= 1'b0;
      swap    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
`ifndef UDC_FIXED_PRIO_EN
      prio    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            owner <= gsel;
            busy  <= 1'b1;
`ifndef UDC_FIXED_PRIO_EN
            prio  <= ~gsel;
`endif
            if (op_sel) begin
              state  <= SWP;
              enable <= 1'b1;
              swap   <= 1'b1;
            end else if (len_sel != '0) begin
              state  <= RUN;
              rem    <= len_sel;
              enable <= 1'b1;
            end else begin
              // Zero-length count completes without ever enabling the counter.
              state   <= FIN;
              done    <= 1'b1;
              done_id <= gsel;
            end
          end
        end
        RUN: begin
          // Rem is nonzero throughout RUN, so this decrement cannot wrap.
          rem <= rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            state   <= FIN;
            enable  <= 1'b0;
            done    <= 1'b1;
            done_id <= owner;
          end
        end
        SWP: begin
          state   <= FIN;
          enable  <= 1'b0;
          swap    <= 1'b0;
          done    <= 1'b1;
          done_id <= owner;
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          enable <= 1'b0;
          swap   <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ReqReady = grant;
  assign bus.Enable   = enable;
  assign bus.Swap     = swap;
  assign bus.Busy     = busy;
  assign bus.Done     = done;
  assign bus.DoneId   = done_id;

endmodule

// File: tb/tb_updown_count_sched.sv
// Self-checking bench for updown_count_sched: directed scenarios plus a randomized
// run checked against a per-cycle timeline model of the command schedule.
module tb_updown_count_sched;

`ifdef UDC_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic Clock = 1'b0;
  logic Reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  updown_count_sched_if #(.LEN_W(4)) bus ();

  updown_count_sched #(.LEN_W(4)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clock = ~Clock;

  // Expected per-cycle outputs while a command is in flight.
  typedef struct packed {
    logic en;
    logic sw;
    logic busy;
    logic done;
    logic id;
  } exp_t;

  exp_t q[$];
  logic m_prio;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset_n      = 1'b0;
    bus.ReqValid = 2'b00;
    bus.ReqOp    = 2'b00;
    bus.ReqLen   = 8'h00;
    tick();
    tick();
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    Reset_n      = 1'b0;
    bus.ReqValid = 2'b11;
    bus.ReqOp    = 2'b00;
    bus.ReqLen   = 8'h11;
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge Clock);
      n_tests++;
      if ({bus.ReqReady, bus.Enable, bus.Swap, bus.Busy, bus.Done, bus.DoneId} !== 7'b0) begin
        n_fail++;
        $display("FAIL reset_state: got rdy=%b en=%b sw=%b busy=%b done=%b id=%b, expected all 0",
                 bus.ReqReady, bus.Enable, bus.Swap, bus.Busy, bus.Done, bus.DoneId);
      end
    end
    tick();
    Reset_n = 1'b1;
    @(negedge Clock);
    n_tests++;
    if (bus.ReqReady !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_first_grant: got %b expected 01", bus.ReqReady);
    end
  endtask

  task automatic test_single_count();
    logic [3:0] exp;
    do_reset();
    bus.ReqValid = 2'b10;
    bus.ReqOp    = 2'b00;
    bus.ReqLen   = 8'h50;
    for (int c = 0; c <= 7; c++) begin
      @(negedge Clock);
      // {Enable, Swap, Busy, Done}
      exp = (c == 0 || c == 7) ? 4'b0000 : (c <= 5) ? 4'b1010 : 4'b0011;
      n_tests++;
      if ({bus.Enable, bus.Swap, bus.Busy, bus.Done} !== exp) begin
        n_fail++;
        $display("FAIL count_outputs c=%0d: got %b expected %b", c,
                 {bus.Enable, bus.Swap, bus.Busy, bus.Done}, exp);
      end
      n_tests++;
      if (bus.ReqReady !== ((c == 0 || c == 7) ? 2'b10 : 2'b00)) begin
        n_fail++;
        $display("FAIL count_ready c=%0d: got %b", c, bus.ReqReady);
      end
      if (c == 6) begin
        n_tests++;
        if (bus.DoneId !== 1'b1) begin
          n_fail++;
          $display("FAIL count_doneid: got %b expected 1", bus.DoneId);
        end
      end
      tick();
    end
  endtask

  task automatic test_swap();
    logic [3:0] exp;
    do_reset();
    bus.ReqValid = 2'b01;
    bus.ReqOp    = 2'b01;
    bus.ReqLen   = 8'h09;
    for (int c = 0; c <= 3; c++) begin
      @(negedge Clock);
      if (c == 0) begin
        n_tests++;
        if (bus.ReqReady !== 2'b01) begin
          n_fail++;
          $display("FAIL swap_ready: got %b expected 01", bus.ReqReady);
        end
      end
      exp = (c == 1) ? 4'b1110 : (c == 2) ? 4'b0011 : 4'b0000;
      n_tests++;
      if ({bus.Enable, bus.Swap, bus.Busy, bus.Done} !== exp) begin
        n_fail++;
        $display("FAIL swap_outputs c=%0d: got %b expected %b", c,
                 {bus.Enable, bus.Swap, bus.Busy, bus.Done}, exp);
      end
      if (c == 2) begin
        n_tests++;
        if (bus.DoneId !== 1'b0) begin
          n_fail++;
          $display("FAIL swap_doneid: got %b expected 0", bus.DoneId);
        end
      end
      tick();
      bus.ReqValid = 2'b00;
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    do_reset();
    bus.ReqValid = 2'b11;
    bus.ReqOp    = 2'b00;
    bus.ReqLen   = 8'h22;
    for (int c = 0; c < 16; c++) begin
      @(negedge Clock);
      exp_g = (FIXED || ((c / 4) % 2 == 0)) ? 2'b01 : 2'b10;
      n_tests++;
      if (bus.ReqReady !== ((c % 4 == 0) ? exp_g : 2'b00)) begin
        n_fail++;
        $display("FAIL rr_grant c=%0d: got %b expected %b", c, bus.ReqReady,
                 (c % 4 == 0) ? exp_g : 2'b00);
      end
      if (c % 4 == 3) begin
        n_tests++;
        if ({bus.Done, bus.DoneId} !== {1'b1, exp_g[1]}) begin
          n_fail++;
          $display("FAIL rr_done c=%0d: got done=%b id=%b expected id=%b", c,
                   bus.Done, bus.DoneId, exp_g[1]);
        end
      end
      tick();
    end
  endtask

  task automatic test_zero_len();
    logic [3:0] exp;
    do_reset();
    bus.ReqValid = 2'b01;
    bus.ReqOp    = 2'b00;
    bus.ReqLen   = 8'h00;
    for (int c = 0; c <= 2; c++) begin
      @(negedge Clock);
      exp = (c == 1) ? 4'b0011 : 4'b0000;
      n_tests++;
      if ({bus.Enable, bus.Swap, bus.Busy, bus.Done} !== exp) begin
        n_fail++;
        $display("FAIL zero_len c=%0d: got %b expected %b", c,
                 {bus.Enable, bus.Swap, bus.Busy, bus.Done}, exp);
      end
      if (c == 2) begin
        n_tests++;
        if (bus.ReqReady !== 2'b01) begin
          n_fail++;
          $display("FAIL zero_len_reready: got %b expected 01", bus.ReqReady);
        end
      end
      tick();
      if (c == 0) bus.ReqValid = 2'b00;
      if (c == 1) bus.ReqValid = 2'b01;
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.ReqValid = 2'b10;
    bus.ReqOp    = 2'b00;
    bus.ReqLen   = 8'hF0;
    tick();
    bus.ReqValid = 2'b00;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clock);
      n_tests++;
      if ({bus.Enable, bus.Busy} !== 2'b11) begin
        n_fail++;
        $display("FAIL midrst_burst c=%0d: got en=%b busy=%b expected 1 1", c, bus.Enable, bus.Busy);
      end
      if (c < 4) tick();
    end
    Reset_n = 1'b0;
    tick();
    Reset_n      = 1'b1;
    bus.ReqValid = 2'b11;
    bus.ReqOp    = 2'b11;
    @(negedge Clock);
    n_tests++;
    if ({bus.Enable, bus.Busy, bus.Done, bus.ReqReady} !== 5'b00001) begin
      n_fail++;
      $display("FAIL midrst_after: got en=%b busy=%b done=%b rdy=%b expected 0 0 0 01",
               bus.Enable, bus.Busy, bus.Done, bus.ReqReady);
    end
    tick();
    bus.ReqValid = 2'b00;
    @(negedge Clock);
    n_tests++;
    if ({bus.Enable, bus.Swap} !== 2'b11) begin
      n_fail++;
      $display("FAIL midrst_newcmd: got en=%b sw=%b expected 1 1", bus.Enable, bus.Swap);
    end
    tick();
    @(negedge Clock);
    n_tests++;
    if ({bus.Done, bus.DoneId} !== 2'b10) begin
      n_fail++;
      $display("FAIL midrst_done: got done=%b id=%b expected 1 0", bus.Done, bus.DoneId);
    end
  endtask

  // Model: an idle scheduler grants by priority; a granted command becomes a list
  // of future cycles (burst cycles then one completion cycle) consumed one per clock.
  task automatic model_expect(output exp_t e, output logic [1:0] er);
    e  = '0;
    er = 2'b00;
    if (q.size() != 0) e = q[0];
    if (Reset_n && q.size() == 0) begin
      if (bus.ReqValid == 2'b11) er = (FIXED || !m_prio) ? 2'b01 : 2'b10;
      else                      er = bus.ReqValid;
    end
  endtask

  task automatic model_advance(input logic [1:0] er);
    int   g;
    int   len;
    exp_t fin;
    if (!Reset_n) begin
      q.delete();
      m_prio = 1'b0;
    end else if (q.size() != 0) begin
      void'(q.pop_front());
    end else if (er != 2'b00) begin
      g = er[1] ? 1 : 0;
      if (!FIXED) m_prio = (g == 0);
      len = (g == 1) ? int'(bus.ReqLen[7:4]) : int'(bus.ReqLen[3:0]);
      fin = '{en: 1'b0, sw: 1'b0, busy: 1'b1, done: 1'b1, id: 1'(g)};
      if (bus.ReqOp[g]) begin
        q.push_back('{en: 1'b1, sw: 1'b1, busy: 1'b1, done: 1'b0, id: 1'b0});
      end else begin
        for (int k = 0; k < len; k++)
          q.push_back('{en: 1'b1, sw: 1'b0, busy: 1'b1, done: 1'b0, id: 1'b0});
      end
      q.push_back(fin);
    end
  endtask

  task automatic test_random();
    exp_t       e;
    logic [1:0] er;
    logic [1:0] hs;
    do_reset();
    q.delete();
    m_prio = 1'b0;
    hs     = 2'b00;
    for (int n = 0; n < 2000; n++) begin
      Reset_n = ($urandom_range(149) != 0);
      for (int i = 0; i < 2; i++) begin
        if (hs[i]) bus.ReqValid[i] = 1'b0;
        if (!bus.ReqValid[i] && $urandom_range(2) == 0) begin
          bus.ReqValid[i]       = 1'b1;
          bus.ReqOp[i]          = ($urandom_range(3) == 0);
          bus.ReqLen[i*4 +: 4]  = ($urandom_range(4) == 0) ? 4'd0 : 4'($urandom_range(15));
        end
      end
      @(negedge Clock);
      model_expect(e, er);
      n_tests++;
      if (bus.ReqReady !== er) begin
        n_fail++;
        $display("FAIL rand_ready n=%0d: got %b expected %b", n, bus.ReqReady, er);
      end
      n_tests++;
      if ({bus.Enable, bus.Swap, bus.Busy, bus.Done} !== {e.en, e.sw, e.busy, e.done}) begin
        n_fail++;
        $display("FAIL rand_outputs n=%0d: got %b expected %b", n,
                 {bus.Enable, bus.Swap, bus.Busy, bus.Done}, {e.en, e.sw, e.busy, e.done});
      end
      if (e.done) begin
        n_tests++;
        if (bus.DoneId !== e.id) begin
          n_fail++;
          $display("FAIL rand_doneid n=%0d: got %b expected %b", n, bus.DoneId, e.id);
        end
      end
      hs = bus.ReqReady & bus.ReqValid & {2{Reset_n}};
      model_advance(er);
      tick();
    end
  endtask

  initial begin
    Reset_n      = 1'b0;
    bus.ReqValid = 2'b00;
    bus.ReqOp    = 2'b00;
    bus.ReqLen   = 8'h00;
    test_reset();
    test_single_count();
    test_swap();
    test_round_robin();
    test_zero_len();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
